// File: rtl/uart_tx_drain_if.sv
// uart_tx_drain_if: FIFO-side handshake and serial outputs of uart_tx_drain.
interface uart_tx_drain_if #(
  parameter int DATA_BITS = 8
);
  logic                 tx_en;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_pop;
  logic                 tx;
  logic                 busy;
  logic                 frame_done;
  modport master (
    output tx_en, fifo_empty, fifo_rdata,
    input  fifo_pop, tx, busy, frame_done
  );
  modport slave (
    input  tx_en, fifo_empty, fifo_rdata,
    output fifo_pop, tx, busy, frame_done
  );
endinterface

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: UART transmitter draining an upstream FIFO back-to-back; define UART_TX_PARITY_EN for an even-parity bit.
module uart_tx_drain #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input logic            clk,
  input logic            resetN,
  uart_tx_drain_if.slave bus
);
  localparam int BW = $clog2(CLK_DIV);
  localparam int NW = $clog2(DATA_BITS) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
  localparam logic [NW-1:0] BIT_LAST  = NW'(DATA_BITS - 1);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [NW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 baud_last, start_ok, par_bit;
  assign baud_last = baud_q == BAUD_LAST;
  // A new word is taken from IDLE or on the final stop cycle, so frames chain with no gap.
  assign start_ok = resetN && bus.tx_en && !bus.fifo_empty &&
                    (state_q == IDLE || (state_q == STOP && baud_last));
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || baud_last) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = start_ok ? bus.fifo_rdata : shift_q;
    if (start_ok) state_d = START;
    else if (baud_last)
      case (state_q)
        START: state_d = DATA;
        DATA: begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == BIT_LAST) state_d = PARITY;
        end
        PARITY: state_d = STOP;
`else
          if (bit_q == BIT_LAST) state_d = STOP;
        end
`endif
        STOP: state_d = IDLE;
        default: state_d = state_q;
      endcase
    if (state_d != state_q) bit_d = '0;
  end
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
  assign par_d   = start_ok ? ^bus.fifo_rdata : par_q;
  assign par_bit = state_d == PARITY ? par_q : 1'b1;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) par_q <= 1'b0;
    else par_q <= par_d;
`else
  assign par_bit = 1'b1;
`endif
  // tx is computed from the next state so the line changes exactly at bit boundaries.
  always_comb tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : par_bit;
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  assign bus.fifo_pop   = start_ok;
  assign bus.tx         = tx_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.frame_done = state_q == STOP && baud_last;
endmodule

// File: tb/tb_uart_tx_drain.sv
// tb_uart_tx_drain: directed stimulus with a frame scoreboard decoding the serial line.
module tb_uart_tx_drain;
  localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
  localparam int FL = 44;
`else
  localparam int FB = 10;
  localparam int FL = 40;
`endif
  logic clk, resetN;
  uart_tx_drain_if #(.DATA_BITS(8)) bus();
  uart_tx_drain #(.CLK_DIV(CLK_DIV), .DATA_BITS(8)) dut (.clk(clk), .resetN(resetN), .bus(bus));
  logic [7:0]    mem [16];
  int            wr_ptr = 0, rd_ptr = 0;
  int            cyc = 0, pop_n = 0, pop_last = 0, pop_prev = 0, fd_cnt = 0;
  int            n_chk = 0, n_fail = 0;
  logic [FB-1:0] exp_q [$];
  logic [FB-1:0] cur;
  bit            in_frame = 0;
  int            k = 0;
  assign bus.fifo_empty = rd_ptr == wr_ptr;
  assign bus.fifo_rdata = mem[rd_ptr[3:0]];
  always #5 clk = ~clk;
  function automatic void chk(input bit ok, input string name, input int act, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.fifo_pop) begin
      rd_ptr   <= rd_ptr + 1;
      pop_n    <= pop_n + 1;
      pop_prev <= pop_last;
      pop_last <= cyc;
    end
  end
  // Monitor: every frame seen on tx is matched against the next queued expectation.
  always @(negedge clk) begin
    if (!resetN) begin
      in_frame = 0;
      chk(bus.tx && !bus.busy && !bus.frame_done && !bus.fifo_pop, "reset_outputs",
          int'({bus.tx, bus.busy, bus.frame_done, bus.fifo_pop}), 8);
    end else begin
      if (bus.fifo_pop) begin
        chk(!bus.fifo_empty, "pop_when_empty", int'(bus.fifo_empty), 0);
        chk(!in_frame || k == FL - 1, "pop_position", k, FL - 1);
      end
      if (!in_frame && !bus.tx) begin
        chk(exp_q.size() != 0, "unexpected_frame", exp_q.size(), 1);
        cur = exp_q.size() != 0 ? exp_q.pop_front() : '1;
        in_frame = 1;
        k = 0;
      end
      if (in_frame) begin
        chk(bus.tx == cur[k / CLK_DIV], "tx_bit", int'(bus.tx), int'(cur[k / CLK_DIV]));
        chk(bus.busy, "busy_in_frame", int'(bus.busy), 1);
        chk(bus.frame_done == (k == FL - 1), "frame_done", int'(bus.frame_done), int'(k == FL - 1));
        if (bus.frame_done) fd_cnt++;
        k++;
        if (k == FL) in_frame = 0;
      end else begin
        chk(!bus.busy && !bus.frame_done, "idle_outputs", int'({bus.busy, bus.frame_done}), 0);
      end
    end
  end
  task automatic push(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr++;
`ifdef UART_TX_PARITY_EN
    exp_q.push_back({1'b1, ^d, d, 1'b0});
`else
    exp_q.push_back({1'b1, d, 1'b0});
`endif
  endtask
`ifdef UART_TX_PARITY_EN
  task automatic push_p(input logic [7:0] d, input logic p);
    mem[wr_ptr[3:0]] = d;
    wr_ptr++;
    exp_q.push_back({1'b1, p, d, 1'b0});
  endtask
`endif
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_busy(input int lim);
    int n = 0;
    while (!bus.busy && n < lim) begin step(); n++; end
    chk(bus.busy, "busy_rise_timeout", int'(bus.busy), 1);
  endtask
  task automatic wait_idle(input int lim, output int n);
    n = 0;
    while (bus.busy && n < lim) begin step(); n++; end
    chk(!bus.busy, "busy_fall_timeout", int'(bus.busy), 0);
  endtask
  task automatic measure(output int run);
    wait_busy(20);
    wait_idle(4 * FL, run);
  endtask
  initial begin
    int p0, f0, run, viol;
    clk = 0;
    resetN = 1;
    bus.tx_en = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hC3;
    #1 resetN = 0;
    bus.tx_en = 1;
    push(8'hA5);
    step();
    step();
    chk(bus.tx == 1'b1, "reset_tx", int'(bus.tx), 1);
    chk(bus.busy == 1'b0, "reset_busy", int'(bus.busy), 0);
    chk(bus.frame_done == 1'b0, "reset_frame_done", int'(bus.frame_done), 0);
    chk(bus.fifo_pop == 1'b0, "reset_pop", int'(bus.fifo_pop), 0);
    p0 = pop_n;
    f0 = fd_cnt;
    resetN = 1;
    #1 chk(bus.fifo_pop == 1'b1, "idle_pop", int'(bus.fifo_pop), 1);
    measure(run);
    chk(run == FL, "a5_busy_cycles", run, FL);
    chk(pop_n - p0 == 1, "a5_pops", pop_n - p0, 1);
    chk(fd_cnt - f0 == 1, "a5_frame_done_count", fd_cnt - f0, 1);
    p0 = pop_n;
    f0 = fd_cnt;
    push(8'h11);
    push(8'h22);
    measure(run);
    chk(run == 2 * FL, "b2b_busy_cycles", run, 2 * FL);
    chk(pop_n - p0 == 2, "b2b_pops", pop_n - p0, 2);
    chk(pop_last - pop_prev == FL, "b2b_pop_gap", pop_last - pop_prev, FL);
    chk(fd_cnt - f0 == 2, "b2b_frame_done_count", fd_cnt - f0, 2);
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (bus.fifo_pop || !bus.tx || bus.busy) viol++;
    end
    chk(viol == 0, "empty_idle_violations", viol, 0);
    p0 = pop_n;
    push(8'h55);
    push(8'h3C);
    wait_busy(20);
    repeat (9) step();
    bus.tx_en = 0;
    wait_idle(4 * FL, run);
    chk(run == FL - 9, "txen_off_finish", run, FL - 9);
    repeat (10) step();
    chk(pop_n - p0 == 1, "txen_off_pops", pop_n - p0, 1);
    chk(bus.tx == 1'b1 && !bus.busy, "txen_off_idle", int'({bus.tx, bus.busy}), 2);
    bus.tx_en = 1;
    #1 chk(bus.fifo_pop == 1'b1, "txen_on_pop", int'(bus.fifo_pop), 1);
    measure(run);
    chk(run == FL, "txen_on_frame", run, FL);
    chk(pop_n - p0 == 2, "txen_total_pops", pop_n - p0, 2);
    p0 = pop_n;
    push(8'h96);
    push(8'h5A);
    wait_busy(20);
    repeat (19) step();
    chk(bus.tx == 1'b0, "pre_reset_tx", int'(bus.tx), 0);
    resetN = 0;
    #1;
    chk(bus.tx == 1'b1, "midreset_tx", int'(bus.tx), 1);
    chk(bus.busy == 1'b0, "midreset_busy", int'(bus.busy), 0);
    chk(bus.fifo_pop == 1'b0, "midreset_pop", int'(bus.fifo_pop), 0);
    step();
    resetN = 1;
    #1 chk(bus.fifo_pop == 1'b1, "post_reset_pop", int'(bus.fifo_pop), 1);
    measure(run);
    chk(run == FL, "post_reset_frame", run, FL);
    chk(pop_n - p0 == 2, "reset_scenario_pops", pop_n - p0, 2);
`ifdef UART_TX_PARITY_EN
    p0 = pop_n;
    push_p(8'h07, 1'b1);
    push_p(8'h03, 1'b0);
    measure(run);
    chk(run == 2 * FL, "parity_busy_cycles", run, 2 * FL);
    chk(pop_last - pop_prev == FL, "parity_pop_gap", pop_last - pop_prev, FL);
    chk(pop_n - p0 == 2, "parity_pops", pop_n - p0, 2);
`endif
    repeat (5) step();
    chk(exp_q.size() == 0, "all_frames_seen", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16, meaning clk cycles per serial bit (legal >= 2).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning payload bits per frame (legal 5..8).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_en  input  1  permits starting new frames.
REQ-006 SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-007 SHALL have port fifo_rdata  input  DATA_BITS  upstream FIFO head word, valid while fifo_empty=0.
REQ-008 SHALL have port fifo_pop  output  1  one-cycle pop strobe to upstream FIFO.
REQ-009 SHALL have port tx  output  1  serial line, idle high.
REQ-010 SHALL have port busy  output  1  high while a frame is on the line.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse on the last cycle of each stop bit.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY (macro-gated), STOP.
REQ-013 SHALL, in IDLE with tx_en=1 and fifo_empty=0, assert fifo_pop combinationally, latch fifo_rdata into a shift register on that edge, and enter START.
REQ-014 SHALL drive tx=0 in START, data bits LSB-first in DATA, tx=1 in STOP, with each bit held exactly CLK_DIV cycles.
REQ-015 SHALL use a baud counter of width $clog2(CLK_DIV), counting 0..CLK_DIV-1, plus a bit counter of width $clog2(DATA_BITS)+1, both cleared on every state entry.
REQ-016 SHALL, without parity, produce a frame of (DATA_BITS+2)*CLK_DIV cycles starting the cycle after the pop.
REQ-017 SHALL, on the last STOP cycle with tx_en=1 and fifo_empty=0, assert fifo_pop, latch the new word and go directly to START, giving zero idle cycles between frames.
REQ-018 SHALL otherwise go from the last STOP cycle to IDLE.
REQ-019 SHALL never assert fifo_pop while fifo_empty=1, at most once per frame, and only in IDLE or on the last STOP cycle.
REQ-020 SHALL always complete an in-flight frame when tx_en falls; tx_en gates only new frame starts.
REQ-021 SHALL ignore fifo_rdata changes after the latch edge.
REQ-022 SHALL assert busy in every state except IDLE.
REQ-023 SHALL pulse frame_done for one cycle on the last STOP cycle, including during back-to-back frames.
REQ-024 SHALL register tx with no combinational path to inputs.

Reset
REQ-025 SHALL, with resetN low, asynchronously force state=IDLE, tx=1, busy=0, frame_done=0 and all counters and the shift register to 0.
REQ-026 SHALL hold fifo_pop=0 while resetN is low, regardless of fifo_empty.
REQ-027 SHALL, on reset mid-frame, abandon the frame and return tx to 1 immediately, with no pop on the first cycle after release unless the IDLE conditions in REQ-013 hold.

Configuration
REQ-028 SHALL, with macro UART_TX_PARITY_EN defined, insert a PARITY state after DATA lasting CLK_DIV cycles that drives even parity (XOR of the latched data bits), so the frame is (DATA_BITS+3)*CLK_DIV cycles.
REQ-029 SHALL, without UART_TX_PARITY_EN, have no PARITY state or parity logic, and go from DATA directly to STOP.

Verification
REQ-030 SHALL cover: CLK_DIV=4, no parity, fifo holds 0xA5, tx_en=1 -> one pop, then tx = 0,1,0,1,0,0,1,0,1,1 with each bit 4 cycles (40 cycles), frame_done at cycle 40, then busy=0.
REQ-031 SHALL cover: CLK_DIV=4, fifo holds 0x11 then 0x22 -> second pop on cycle 40 (the last STOP cycle), second start bit on cycle 41, tx never idles between frames, 80 busy cycles, exactly two pops.
REQ-032 SHALL cover: fifo_empty=1 for 100 cycles with tx_en=1 -> fifo_pop=0, tx=1, busy=0 throughout.
REQ-033 SHALL cover: tx_en dropped on cycle 10 of a frame with 0x3C queued behind it -> the current frame finishes, no further pop, tx=1 afterwards; raising tx_en -> pop on the next cycle.
REQ-034 SHALL cover: resetN pulsed low on cycle 20 of a frame -> tx=1 and busy=0 in the same cycle; after release with fifo non-empty, a new frame starts cleanly.
REQ-035 SHALL cover: with UART_TX_PARITY_EN, CLK_DIV=4, data 0x07 -> parity bit=1, and data 0x03 -> parity bit=0; frame length 44 cycles.
